// File: rtl/decode_sequencer_pkg.sv
// Shared definitions for the decode sequencer: RV32I/RV32M opcode, funct3
// and funct7 constants, ALU control codes, operand-select and access-size
// codes, the decoded-control bundle and the sequencer state type.
package decode_sequencer_pkg;

  // Major opcodes
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // funct3: ALU ops
  localparam logic [2:0] F3_ADD_SUB = 3'd0;
  localparam logic [2:0] F3_SLL     = 3'd1;
  localparam logic [2:0] F3_SLT     = 3'd2;
  localparam logic [2:0] F3_SLTU    = 3'd3;
  localparam logic [2:0] F3_XOR     = 3'd4;
  localparam logic [2:0] F3_SRL_SRA = 3'd5;
  localparam logic [2:0] F3_OR      = 3'd6;
  localparam logic [2:0] F3_AND     = 3'd7;

  // funct3: branches
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // funct3: M-extension ops (bit 2 set selects the divider class)
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  // funct7
  localparam logic [6:0] F7_BASE    = 7'b0000000;
  localparam logic [6:0] F7_ALT     = 7'b0100000;
  localparam logic [6:0] FUNCT7_MUL = 7'b0000001;

  // ALU control codes
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_INC4 = 4'd10;  // A + 4, link address for jumps

  // Operand selects
  localparam logic [1:0] SRCA_RS1  = 2'd0;
  localparam logic [1:0] SRCA_PC   = 2'd1;
  localparam logic [1:0] SRCA_ZERO = 2'd2;
  localparam logic       SRCB_RS2  = 1'b0;
  localparam logic       SRCB_IMM  = 1'b1;

  // Memory access size
  localparam logic [1:0] SIZE_WORD = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_BYTE = 2'd2;

  // Immediate format one-hot {itype,stype,btype,utype,jtype}
  localparam logic [4:0] IMM_I = 5'b10000;
  localparam logic [4:0] IMM_S = 5'b01000;
  localparam logic [4:0] IMM_B = 5'b00100;
  localparam logic [4:0] IMM_U = 5'b00010;
  localparam logic [4:0] IMM_J = 5'b00001;

  typedef struct packed {
    logic [3:0] aluctrl;
    logic [1:0] alusrca;
    logic       alusrcb;
    logic       memwrite;
    logic [1:0] lwhb;
    logic [1:0] swhb;
    logic       lunsigned;
    logic       memtoreg;
    logic       regwrite;
    logic [4:0] rd;
    logic [2:0] mdu_op;
    logic       mdu_en;
    logic       illegal;
  } ctrl_t;

  typedef enum logic {RUN, MDU_WAIT} state_e;

  // ALU code for OP / OP-IMM; alt selects SUB/SRA
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
      F3_SLL:     return ALU_SLL;
      F3_SLT:     return ALU_SLT;
      F3_SLTU:    return ALU_SLTU;
      F3_XOR:     return ALU_XOR;
      F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
      F3_OR:      return ALU_OR;
      default:    return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/decode_sequencer_if.sv
// ID/EX handshake bundle of the decode sequencer.
// master: instruction source / pipeline driving ID inputs and ex_ready.
// slave : the decode sequencer producing id_ready, pcsrc, immctrl and EX controls.
interface decode_sequencer_if;
  logic [31:0] instr;
  logic        id_valid;
  logic        zero;
  logic        lt;
  logic        flush;
  logic        ex_ready;
  logic        id_ready;
  logic        pcsrc;
  logic [4:0]  immctrl;
  logic        ex_valid;
  logic [3:0]  ex_aluctrl;
  logic [1:0]  ex_alusrca;
  logic        ex_alusrcb;
  logic        ex_memwrite;
  logic [1:0]  ex_lwhb;
  logic [1:0]  ex_swhb;
  logic        ex_lunsigned;
  logic        ex_memtoreg;
  logic        ex_regwrite;
  logic [4:0]  ex_rd;
  logic [2:0]  ex_mdu_op;
  logic        ex_mdu_en;
  logic        ex_mdu_start;
  logic        mdu_busy;
  logic        ex_illegal;

  modport master (
    output instr, id_valid, zero, lt, flush, ex_ready,
    input  id_ready, pcsrc, immctrl, ex_valid, ex_aluctrl, ex_alusrca, ex_alusrcb,
           ex_memwrite, ex_lwhb, ex_swhb, ex_lunsigned, ex_memtoreg, ex_regwrite,
           ex_rd, ex_mdu_op, ex_mdu_en, ex_mdu_start, mdu_busy, ex_illegal
  );

  modport slave (
    input  instr, id_valid, zero, lt, flush, ex_ready,
    output id_ready, pcsrc, immctrl, ex_valid, ex_aluctrl, ex_alusrca, ex_alusrcb,
           ex_memwrite, ex_lwhb, ex_swhb, ex_lunsigned, ex_memtoreg, ex_regwrite,
           ex_rd, ex_mdu_op, ex_mdu_en, ex_mdu_start, mdu_busy, ex_illegal
  );
endinterface

// File: rtl/decode_sequencer_decode_logic.sv
// decode_logic: purely combinational RV32I(+M) decoder.
// Ports: instr (ID word), zero/lt (comparator results) in;
//        ctrl (decoded EX controls), immctrl, uses_rs1/uses_rs2 (for hazard
//        detection) and branch_taken (unqualified) out.
module decode_logic
  import decode_sequencer_pkg::*;
#(
  parameter bit ENABLE_M = 1'b1
) (
  input  logic [31:0] instr,
  input  logic        zero,
  input  logic        lt,
  output ctrl_t       ctrl,
  output logic [4:0]  immctrl,
  output logic        uses_rs1,
  output logic        uses_rs2,
  output logic        branch_taken
);
  logic [6:0] opcode;
  logic [2:0] f3;
  logic [6:0] f7;
  logic       legal;

  assign opcode = instr[6:0];
  assign f3     = instr[14:12];
  assign f7     = instr[31:25];

  always_comb begin
    ctrl         = '0;
    ctrl.rd      = instr[11:7];
    immctrl      = '0;
    uses_rs1     = 1'b0;
    uses_rs2     = 1'b0;
    branch_taken = 1'b0;
    legal        = 1'b0;
    case (opcode)
      OPC_LUI: begin
        legal = 1'b1; ctrl.regwrite = 1'b1; immctrl = IMM_U;
        ctrl.alusrca = SRCA_ZERO; ctrl.alusrcb = SRCB_IMM;
      end
      OPC_AUIPC: begin
        legal = 1'b1; ctrl.regwrite = 1'b1; immctrl = IMM_U;
        ctrl.alusrca = SRCA_PC; ctrl.alusrcb = SRCB_IMM;
      end
      OPC_JAL: begin
        legal = 1'b1; ctrl.regwrite = 1'b1; immctrl = IMM_J;
        ctrl.alusrca = SRCA_PC; ctrl.aluctrl = ALU_INC4; branch_taken = 1'b1;
      end
      OPC_JALR: begin
        legal = (f3 == 3'd0); ctrl.regwrite = 1'b1; immctrl = IMM_I; uses_rs1 = 1'b1;
        ctrl.alusrca = SRCA_PC; ctrl.aluctrl = ALU_INC4; branch_taken = 1'b1;
      end
      OPC_BRANCH: begin
        legal = 1'b1; immctrl = IMM_B; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl.aluctrl = ALU_SUB;
        // The ID comparator delivers lt with the signedness of this funct3.
        case (f3)
          F3_BEQ:           branch_taken = zero;
          F3_BNE:           branch_taken = !zero;
          F3_BLT, F3_BLTU:  branch_taken = lt;
          F3_BGE, F3_BGEU:  branch_taken = !lt;
          default:          legal = 1'b0;
        endcase
      end
      OPC_LOAD: begin
        legal = 1'b1; immctrl = IMM_I; uses_rs1 = 1'b1; ctrl.alusrcb = SRCB_IMM;
        ctrl.memtoreg = 1'b1; ctrl.regwrite = 1'b1;
        case (f3)
          3'd0:    ctrl.lwhb = SIZE_BYTE;
          3'd1:    ctrl.lwhb = SIZE_HALF;
          3'd2:    ctrl.lwhb = SIZE_WORD;
          3'd4:    begin ctrl.lwhb = SIZE_BYTE; ctrl.lunsigned = 1'b1; end
          3'd5:    begin ctrl.lwhb = SIZE_HALF; ctrl.lunsigned = 1'b1; end
          default: legal = 1'b0;
        endcase
      end
      OPC_STORE: begin
        legal = 1'b1; immctrl = IMM_S; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        ctrl.alusrcb = SRCB_IMM; ctrl.memwrite = 1'b1;
        case (f3)
          3'd0:    ctrl.swhb = SIZE_BYTE;
          3'd1:    ctrl.swhb = SIZE_HALF;
          3'd2:    ctrl.swhb = SIZE_WORD;
          default: legal = 1'b0;
        endcase
      end
      OPC_OP_IMM: begin
        immctrl = IMM_I; uses_rs1 = 1'b1; ctrl.alusrcb = SRCB_IMM; ctrl.regwrite = 1'b1;
        // Only shift-immediates constrain the upper bits; SRAI uses funct7 bit 5.
        if (f3 == F3_SLL)          legal = (f7 == F7_BASE);
        else if (f3 == F3_SRL_SRA) legal = (f7 == F7_BASE) || (f7 == F7_ALT);
        else                       legal = 1'b1;
        ctrl.aluctrl = alu_from_f3(f3, (f3 == F3_SRL_SRA) && f7[5]);
      end
      OPC_OP: begin
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; ctrl.regwrite = 1'b1;
        if (f7 == FUNCT7_MUL) begin
          legal       = ENABLE_M;
          ctrl.mdu_en = ENABLE_M;
          ctrl.mdu_op = f3;
        end else if (f7 == F7_BASE) begin
          legal = 1'b1;
          ctrl.aluctrl = alu_from_f3(f3, 1'b0);
        end else if (f7 == F7_ALT) begin
          legal = (f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA);
          ctrl.aluctrl = alu_from_f3(f3, 1'b1);
        end
      end
      default: legal = 1'b0;
    endcase

    // Illegal words must have no architectural side effect and read no registers.
    if (!legal) begin
      ctrl.illegal  = 1'b1;
      ctrl.regwrite = 1'b0;
      ctrl.memwrite = 1'b0;
      ctrl.memtoreg = 1'b0;
      ctrl.mdu_en   = 1'b0;
      uses_rs1      = 1'b0;
      uses_rs2      = 1'b0;
      branch_taken  = 1'b0;
    end
  end
endmodule

// File: rtl/decode_sequencer.sv
// decode_sequencer: ID-stage handshake, load-use interlock, multi-cycle
// M-op sequencing (RUN / MDU_WAIT) and the registered EX control stage.
// Ports: clk, reset (async, active-high), bus (decode_sequencer_if.slave)
// carrying the ID inputs, ex_ready, and all ID/EX outputs.
module decode_sequencer
  import decode_sequencer_pkg::*;
#(
  parameter int DIV_CYCLES = 32,   // 2..64
  parameter int MUL_CYCLES = 1,    // 1..8
  parameter bit ENABLE_M   = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  decode_sequencer_if.slave  bus
);
  // Sized for the divider latency; MUL_CYCLES is expected not to exceed DIV_CYCLES.
  localparam int CNT_W = $clog2(DIV_CYCLES + 1);
  localparam logic [CNT_W-1:0] DIV_LOAD = CNT_W'(DIV_CYCLES - 1);
  localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

  ctrl_t            dec_ctrl;
  logic [4:0]       dec_immctrl;
  logic             uses_rs1, uses_rs2, branch_taken;
  ctrl_t            ex_ctrl_reg;
  logic             ex_valid_reg;
  logic             ex_mdu_start_reg;
  state_e           state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic             load_use, id_ready, accept, long_mdu;
  logic [CNT_W-1:0] mdu_load;

  decode_logic #(.ENABLE_M(ENABLE_M)) u_decode (
    .instr        (bus.instr),
    .zero         (bus.zero),
    .lt           (bus.lt),
    .ctrl         (dec_ctrl),
    .immctrl      (dec_immctrl),
    .uses_rs1     (uses_rs1),
    .uses_rs2     (uses_rs2),
    .branch_taken (branch_taken)
  );

  assign load_use = ex_valid_reg && ex_ctrl_reg.memtoreg && (ex_ctrl_reg.rd != 5'd0) &&
                    ((uses_rs1 && (ex_ctrl_reg.rd == bus.instr[19:15])) ||
                     (uses_rs2 && (ex_ctrl_reg.rd == bus.instr[24:20])));
  assign id_ready = (state_reg == RUN) && (!ex_valid_reg || bus.ex_ready) &&
                    !load_use && !bus.flush;
  assign accept   = bus.id_valid && id_ready;
  // funct3 bit 2 distinguishes DIV/DIVU/REM/REMU from the multiplies.
  assign mdu_load = dec_ctrl.mdu_op[2] ? DIV_LOAD : MUL_LOAD;
  assign long_mdu = dec_ctrl.mdu_en && (mdu_load != '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg        <= RUN;
      cnt_reg          <= '0;
      ex_valid_reg     <= 1'b0;
      ex_mdu_start_reg <= 1'b0;
      ex_ctrl_reg      <= '0;
    end else begin
      // Start is a single-cycle pulse even if EX stalls the op afterwards.
      ex_mdu_start_reg <= 1'b0;
      if (bus.flush) begin
        state_reg           <= RUN;
        cnt_reg             <= '0;
        ex_valid_reg        <= 1'b0;
        ex_ctrl_reg.illegal <= 1'b0;
      end else if (state_reg == MDU_WAIT) begin
        // The M-op sits in EX invisible until its latency has elapsed.
        if (cnt_reg <= CNT_W'(1)) begin
          state_reg    <= RUN;
          cnt_reg      <= '0;
          ex_valid_reg <= 1'b1;
        end else begin
          cnt_reg <= cnt_reg - CNT_W'(1);
        end
      end else if (accept) begin
        ex_ctrl_reg      <= dec_ctrl;
        ex_mdu_start_reg <= dec_ctrl.mdu_en;
        if (long_mdu) begin
          state_reg    <= MDU_WAIT;
          cnt_reg      <= mdu_load;
          ex_valid_reg <= 1'b0;
        end else begin
          ex_valid_reg <= 1'b1;
        end
      end else if (bus.ex_ready) begin
        ex_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.id_ready     = id_ready;
  assign bus.pcsrc        = branch_taken && accept;
  assign bus.immctrl      = dec_immctrl;
  assign bus.ex_valid     = ex_valid_reg;
  assign bus.ex_aluctrl   = ex_ctrl_reg.aluctrl;
  assign bus.ex_alusrca   = ex_ctrl_reg.alusrca;
  assign bus.ex_alusrcb   = ex_ctrl_reg.alusrcb;
  assign bus.ex_memwrite  = ex_ctrl_reg.memwrite;
  assign bus.ex_lwhb      = ex_ctrl_reg.lwhb;
  assign bus.ex_swhb      = ex_ctrl_reg.swhb;
  assign bus.ex_lunsigned = ex_ctrl_reg.lunsigned;
  assign bus.ex_memtoreg  = ex_ctrl_reg.memtoreg;
  assign bus.ex_regwrite  = ex_ctrl_reg.regwrite;
  assign bus.ex_rd        = ex_ctrl_reg.rd;
  assign bus.ex_mdu_op    = ex_ctrl_reg.mdu_op;
  assign bus.ex_mdu_en    = ex_ctrl_reg.mdu_en;
  assign bus.ex_mdu_start = ex_mdu_start_reg;
  assign bus.mdu_busy     = (state_reg == MDU_WAIT);
  assign bus.ex_illegal   = ex_ctrl_reg.illegal;
endmodule
